// File: rtl/sram_1r1w_init.sv
// sram_1r1w_init: 1R1W SRAM with lane-masked writes, 1/2-cycle read latency and a post-reset INIT_VALUE sweep.
// Define SRAM_RD_BYPASS_EN for write-first forwarding on a same-cycle same-address read/write.
module sram_1r1w_init #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH = 512,
    parameter int MASK_GRAN = 8,
    parameter int OUT_REG = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int MW = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  W0_en,
    input  logic [AW-1:0]         W0_addr,
    input  logic [DATA_WIDTH-1:0] W0_data,
    input  logic [MW-1:0]         W0_mask,
    input  logic                  R0_en,
    input  logic [AW-1:0]         R0_addr,
    output logic [DATA_WIDTH-1:0] R0_data,
    output logic                  R0_valid,
    output logic                  init_busy
);
    if (DATA_WIDTH % MASK_GRAN != 0) begin : g_gran_check
        $error("DATA_WIDTH must be a multiple of MASK_GRAN");
    end

    typedef enum logic {INIT, READY} state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic busy, wr_in, rd_in, wr_en, rd_acc, rv1_q;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_lanes;
    logic [DATA_WIDTH-1:0] wr_data, rd_raw, rd_word, rd1_q;

    assign busy = state_q == INIT;
    assign init_busy = busy;
    assign wr_in = {1'b0, W0_addr} < DEPTH_C;
    assign rd_in = {1'b0, R0_addr} < DEPTH_C;
    assign wr_en = busy || (W0_en && wr_in);
    assign wr_addr = busy ? cnt_q : W0_addr;
    assign wr_data = busy ? INIT_VALUE : W0_data;
    assign wr_lanes = busy ? '1 : W0_mask;
    assign rd_acc = !busy && R0_en;
    assign rd_raw = rd_in ? mem[R0_addr] : '0;

`ifdef SRAM_RD_BYPASS_EN
    logic [DATA_WIDTH-1:0] bit_mask;
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < MW; i++) bit_mask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
    end
    assign rd_word = (W0_en && !busy && wr_in && W0_addr == R0_addr) ?
                     (W0_data & bit_mask) | (rd_raw & ~bit_mask) : rd_raw;
`else
    assign rd_word = rd_raw;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? READY : INIT;
        end
    end

    // Storage is deliberately not reset; the sweep clears it instead.
    always_ff @(posedge clock) begin
        for (int i = 0; i < MW; i++)
            if (wr_en && wr_lanes[i]) mem[wr_addr][i*MASK_GRAN +: MASK_GRAN] <= wr_data[i*MASK_GRAN +: MASK_GRAN];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q <= '0;
            rv1_q <= 1'b0;
            rd1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rv1_q <= rd_acc;
            if (rd_acc) rd1_q <= rd_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic rv2_q;
        logic [DATA_WIDTH-1:0] rd2_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rv2_q <= 1'b0;
                rd2_q <= '0;
            end else begin
                rv2_q <= rv1_q;
                if (rv1_q) rd2_q <= rd1_q;
            end
        end
        assign R0_valid = rv2_q;
        assign R0_data = rd2_q;
    end else begin : g_no_out_reg
        assign R0_valid = rv1_q;
        assign R0_data = rd1_q;
    end
endmodule

// File: tb/tb_sram_1r1w_init.sv
// tb_sram_1r1w_init: two instances (DEPTH=12/latency 1 and DEPTH=16/latency 2) checked each cycle against an array/queue model.
module tb_sram_1r1w_init;
    localparam int DW = 64, G = 8, MW = 8, AW = 4;
    localparam logic [DW-1:0] IV0 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [DW-1:0] IV1 = 64'h0123_4567_89AB_CDEF;

    typedef struct {int dut; int due; logic [DW-1:0] v;} pend_t;

    logic clock = 1'b0, reset = 1'b1;
    logic w_en = 1'b0, r_en = 1'b0;
    logic [AW-1:0] w_addr = '0, r_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic [MW-1:0] w_mask = '0;
    logic [DW-1:0] rd0, rd1;
    logic rv0, rv1, busy0, busy1;
    int checks = 0, errors = 0;

    logic [DW-1:0] m [2][16];
    int left [2];
    int dep [2] = '{12, 16};
    int lat [2] = '{1, 2};
    logic [DW-1:0] iv [2];
    logic ev [2];
    logic [DW-1:0] ed [2];
    pend_t pq [$];
    int cyc = 0;

    always #5 clock = ~clock;

    sram_1r1w_init #(.DATA_WIDTH(DW), .DEPTH(12), .MASK_GRAN(G), .OUT_REG(0), .INIT_VALUE(IV0)) u0 (
        .clock(clock), .reset(reset), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
        .R0_en(r_en), .R0_addr(r_addr), .R0_data(rd0), .R0_valid(rv0), .init_busy(busy0));

    sram_1r1w_init #(.DATA_WIDTH(DW), .DEPTH(16), .MASK_GRAN(G), .OUT_REG(1), .INIT_VALUE(IV1)) u1 (
        .clock(clock), .reset(reset), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
        .R0_en(r_en), .R0_addr(r_addr), .R0_data(rd1), .R0_valid(rv1), .init_busy(busy1));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            left[k] = dep[k];
            ev[k] = 1'b0;
            ed[k] = '0;
        end
        pq.delete();
    endtask

    task automatic model_edge();
        logic [DW-1:0] bm, rv;
        logic wok;
        cyc++;
        bm = '0;
        for (int i = 0; i < MW; i++) if (w_mask[i]) bm[i*G +: G] = '1;
        for (int k = 0; k < 2; k++) begin
            if (left[k] > 0) begin
                m[k][dep[k] - left[k]] = iv[k];
                left[k]--;
            end else begin
                wok = w_en && (int'(w_addr) < dep[k]);
                if (r_en) begin
                    rv = (int'(r_addr) < dep[k]) ? m[k][r_addr] : '0;
`ifdef SRAM_RD_BYPASS_EN
                    if (wok && w_addr == r_addr) rv = (w_data & bm) | (rv & ~bm);
`endif
                    pq.push_back('{k, cyc + lat[k] - 1, rv});
                end
                if (wok) m[k][w_addr] = (w_data & bm) | (m[k][w_addr] & ~bm);
            end
        end
        ev[0] = 1'b0;
        ev[1] = 1'b0;
        for (int j = pq.size() - 1; j >= 0; j--) begin
            if (pq[j].due == cyc) begin
                ev[pq[j].dut] = 1'b1;
                ed[pq[j].dut] = pq[j].v;
                pq.delete(j);
            end
        end
    endtask

    task automatic check_all();
        chk("busy0", DW'(busy0), DW'(left[0] > 0));
        chk("busy1", DW'(busy1), DW'(left[1] > 0));
        chk("valid0", DW'(rv0), DW'(ev[0]));
        chk("valid1", DW'(rv1), DW'(ev[1]));
        chk("data0", rd0, ed[0]);
        chk("data1", rd1, ed[1]);
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) model_edge();
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic count_sweep(output int c0, output int c1);
        c0 = 1;
        c1 = 1;
        for (int i = 0; i < 40 && (busy0 || busy1); i++) begin
            if (i == 8) begin
                w_en = 1'b0;
                r_en = 1'b0;
            end
            step();
            if (busy0) c0++;
            if (busy1) c1++;
        end
    endtask

    initial begin
        int c0, c1;
        iv[0] = IV0;
        iv[1] = IV1;
        model_reset();
        step();
        // Requests during the sweep must be ignored, including a write to addr 2.
        reset = 1'b0;
        w_en = 1'b1; w_addr = 4'd2; w_data = '1; w_mask = '1;
        r_en = 1'b1; r_addr = 4'd2;
        count_sweep(c0, c1);
        chk("sweep_len0", DW'(c0), DW'(12));
        chk("sweep_len1", DW'(c1), DW'(16));
        w_en = 1'b0;
        r_en = 1'b0;
        r_en = 1'b1; r_addr = 4'd2;
        step();
        r_en = 1'b0;
        chk("init_kept0", rd0, IV0);
        step();
        chk("init_kept1", rd1, IV1);
        for (int a = 0; a < 16; a++) begin
            r_en = 1'b1; r_addr = AW'(a);
            step();
            chk("sweep_rv0", DW'(rv0), DW'(1));
            chk("sweep_rd0", rd0, (a < 12) ? IV0 : '0);
        end
        r_en = 1'b0;
        step();
        step();
        w_en = 1'b1; w_addr = 4'd3; w_data = 64'h1122_3344_5566_7788; w_mask = 8'h0F;
        step();
        w_en = 1'b0;
        r_en = 1'b1; r_addr = 4'd3;
        step();
        r_en = 1'b0;
        chk("mask0", rd0, 64'hA5A5_A5A5_5566_7788);
        step();
        chk("mask1", rd1, 64'h0123_4567_5566_7788);
        w_en = 1'b1; w_addr = 4'd5; w_data = '1; w_mask = '1;
        r_en = 1'b1; r_addr = 4'd5;
        step();
        w_en = 1'b0;
`ifdef SRAM_RD_BYPASS_EN
        chk("rdw0", rd0, '1);
`else
        chk("rdw0", rd0, IV0);
`endif
        step();
        r_en = 1'b0;
        chk("after_rdw0", rd0, '1);
        step();
        chk("after_rdw1", rd1, '1);
        step();
        for (int i = 0; i < 300; i++) begin
            w_en = 1'($urandom); w_addr = AW'($urandom); w_data = {$urandom, $urandom}; w_mask = MW'($urandom);
            r_en = 1'($urandom); r_addr = (i % 7 == 0) ? w_addr : AW'($urandom);
            step();
        end
        w_en = 1'b0;
        r_en = 1'b1; r_addr = 4'd13;
        step();
        r_en = 1'b0;
        chk("oob_rv0", DW'(rv0), DW'(1));
        chk("oob_rd0", rd0, '0);
        step();
        step();
        // Reset lands while u1's read is still in its output register stage.
        r_en = 1'b1; r_addr = 4'd1;
        step();
        r_en = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        step();
        step();
        reset = 1'b0;
        count_sweep(c0, c1);
        chk("resweep_len0", DW'(c0), DW'(12));
        chk("resweep_len1", DW'(c1), DW'(16));
        r_en = 1'b1; r_addr = 4'd5;
        step();
        r_en = 1'b0;
        chk("resweep_rd0", rd0, IV0);
        step();
        chk("resweep_rd1", rd1, IV1);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
